alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit ALU with flags, followed by PIPE_DEPTH elastic register stages and a tag passthrough.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate as signed instead of wrapping.
module alu_pipe #(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = TAG_W + 5 + WIDTH;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] x_w;
  logic             c_w;
  logic             v_w;
  logic             err_w;

  assign sum_w   = {1'b0, in_a} + {1'b0, in_b};
  assign diff_w  = {1'b0, in_a} - {1'b0, in_b};
  assign shamt   = in_b[SHW-1:0];
  assign add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != in_a[WIDTH-1]);
  assign sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_w[WIDTH-1] != in_a[WIDTH-1]);

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] sat_val;
  // Overflow can only happen toward the sign of a, for both ADD and SUB
  assign sat_val = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  always_comb begin
    x_w   = '0;
    c_w   = 1'b0;
    v_w   = 1'b0;
    err_w = 1'b0;
    case (in_op)
      4'h0: begin
`ifdef ALU_SAT_EN
        x_w = add_ovf ? sat_val : sum_w[WIDTH-1:0];
`else
        x_w = sum_w[WIDTH-1:0];
`endif
        c_w = sum_w[WIDTH];
        v_w = add_ovf;
      end
      4'h1: begin
`ifdef ALU_SAT_EN
        x_w = sub_ovf ? sat_val : diff_w[WIDTH-1:0];
`else
        x_w = diff_w[WIDTH-1:0];
`endif
        c_w = diff_w[WIDTH];
        v_w = sub_ovf;
      end
      4'h2: x_w = ~(in_a | in_b);
      4'h3: x_w = in_a | in_b;
      4'h4: x_w = ~(in_a & in_b);
      4'h5: x_w = in_a & in_b;
      4'h6: x_w = ~(in_a ^ in_b);
      4'h7: x_w = in_a ^ in_b;
      4'h8: x_w = in_a << shamt;
      4'h9: x_w = in_a >> shamt;
      4'hA: x_w = $signed(in_a) >>> shamt;
      4'hB: x_w = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: err_w = 1'b1;
    endcase
  end

  logic [PIPE_DEPTH-1:0] vld_q;
  logic [PIPE_DEPTH-1:0] vld_d;
  logic [PW-1:0]         dat_q [PIPE_DEPTH];
  logic [PW-1:0]         dat_d [PIPE_DEPTH];
  logic [PIPE_DEPTH:0]   rdy_w;
  logic [PW-1:0]         res_w;

  assign res_w = {in_tag, err_w, v_w, c_w, x_w[WIDTH-1], (x_w == '0), x_w};

  // Ready ripples back from the consumer; a stage is free if empty or draining
  always_comb begin
    rdy_w             = '0;
    rdy_w[PIPE_DEPTH] = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      rdy_w[k] = !vld_q[k] || rdy_w[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      logic          src_vld;
      logic [PW-1:0] src_dat;
      if (gi == 0) begin : g_head
        assign src_vld = in_valid;
        assign src_dat = res_w;
      end else begin : g_body
        assign src_vld = vld_q[gi-1];
        assign src_dat = dat_q[gi-1];
      end
      assign vld_d[gi] = rdy_w[gi] ? src_vld : vld_q[gi];
      assign dat_d[gi] = (rdy_w[gi] && src_vld) ? src_dat : dat_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign in_ready  = rdy_w[0];
  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign {out_tag, out_err, out_v, out_c, out_n, out_z, out_x} = dat_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops and compares on each output transfer.
module tb_alu_pipe;
  parameter int WIDTH      = 32;
  parameter int PIPE_DEPTH = 2;
  parameter int TAG_W      = 4;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic             z, n, c, v, err;
    logic [TAG_W-1:0] tag;
    logic             exact;
    logic             tp;
    logic [31:0]      acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic             out_z, out_n, out_c, out_v, out_err;
  logic [TAG_W-1:0] out_tag;

  alu_pipe #(.WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_z(out_z), .out_n(out_n), .out_c(out_c),
    .out_v(out_v), .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t sb_q[$];
  int   tput_cnt = 0;
  int   tput_first = -1;
  int   tput_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain signed/unsigned arithmetic on the operands
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [3:0] op);
    exp_t e;
    logic signed [WIDTH+1:0] sa, sb, r, one_s, maxs, mins;
    logic [WIDTH-1:0] x, tmp;
    int sh;
    e = '0;
    x = '0;
    one_s = 1;
    maxs = (one_s <<< (WIDTH - 1)) - one_s;
    mins = -maxs - one_s;
    sa = {{2{a[WIDTH-1]}}, a};
    sb = {{2{b[WIDTH-1]}}, b};
    sh = int'(b % WIDTH);
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h0) begin
          r = sa + sb;
          tmp = a + b;
          e.c = (tmp < a);
        end else begin
          r = sa - sb;
          e.c = (a < b);
        end
        e.v = (r > maxs) || (r < mins);
        x = r[WIDTH-1:0];
`ifdef ALU_SAT_EN
        if (r > maxs) x = maxs[WIDTH-1:0];
        if (r < mins) x = mins[WIDTH-1:0];
`endif
      end
      4'h2: x = ~(a | b);
      4'h3: x = a | b;
      4'h4: x = ~(a & b);
      4'h5: x = a & b;
      4'h6: x = ~(a ^ b);
      4'h7: x = a ^ b;
      4'h8: x = a << sh;
      4'h9: x = a >> sh;
      4'hA: begin
        r = sa >>> sh;
        x = r[WIDTH-1:0];
      end
      4'hB: x[0] = (sa < sb);
      default: e.err = 1'b1;
    endcase
    e.x = x;
    e.z = (x == '0);
    e.n = x[WIDTH-1];
    return e;
  endfunction

  // Consumer ready: 0 = always ready, 1 = hold off, 2 = random stalls
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] hold_x;
  logic [4:0]       hold_f;
  logic [TAG_W-1:0] hold_tag;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_chk++;
          if (!out_valid || out_x !== hold_x || {out_z, out_n, out_c, out_v, out_err} !== hold_f
              || out_tag !== hold_tag) begin
            n_fail++;
            $display("FAIL hold: got v=%0b x=%h tag=%0d, required v=1 x=%h tag=%0d",
                     out_valid, out_x, out_tag, hold_x, hold_tag);
          end
        end
        prev_stall = 1'b0;
        if (out_valid && !out_ready) begin
          prev_stall = 1'b1;
          hold_x = out_x;
          hold_f = {out_z, out_n, out_c, out_v, out_err};
          hold_tag = out_tag;
        end else if (out_valid && out_ready) begin
          n_chk++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got x=%h tag=%0d, required no output", out_x, out_tag);
          end else begin
            e = sb_q.pop_front();
            if ({out_x, out_z, out_n, out_c, out_v, out_err, out_tag} !==
                {e.x, e.z, e.n, e.c, e.v, e.err, e.tag}) begin
              n_fail++;
              $display("FAIL result: got x=%h z%0b n%0b c%0b v%0b err%0b tag=%0d, required x=%h z%0b n%0b c%0b v%0b err%0b tag=%0d",
                       out_x, out_z, out_n, out_c, out_v, out_err, out_tag,
                       e.x, e.z, e.n, e.c, e.v, e.err, e.tag);
            end
            if (e.exact) begin
              n_chk++;
              if (cyc - int'(e.acc) != PIPE_DEPTH) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles, required %0d", cyc - int'(e.acc), PIPE_DEPTH);
              end
            end
            if (e.tp) begin
              tput_cnt++;
              if (tput_first < 0) tput_first = cyc;
              tput_last = cyc;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic tp);
    exp_t e;
    logic ok;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_tag = tag;
    ok = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      if (in_ready && !reset) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end else begin
      e = model(a, b, op);
      e.tag = tag;
      e.exact = (rdy_mode == 0);
      e.tp = tp;
      e.acc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int g = 0; g < 1000 && sb_q.size() != 0; g++) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
    end
    idle(1);
  endtask

  function automatic logic [WIDTH-1:0] rnd_w();
    logic [63:0] t;
    logic [WIDTH-1:0] w;
    t = {$urandom(), $urandom()};
    w = t[WIDTH-1:0];
    case ($urandom_range(0, 11))
      0: w = '0;
      1: w = '1;
      2: w = {1'b0, {(WIDTH-1){1'b1}}};
      3: w = {1'b1, {(WIDTH-1){1'b0}}};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [WIDTH-1:0] ones_v, maxp_v, one_v, three_v, five_v, sw_a, sw_b, four_v;
    logic [63:0] t64;
    logic [3:0] opv;

    #2000000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ones_v, maxp_v, one_v, three_v, five_v, sw_a, sw_b, four_v;
    logic [63:0] t64;

    ones_v = '1;
    maxp_v = ones_v >> 1;
    one_v = '0;   one_v[0] = 1'b1;
    three_v = '0; three_v[1:0] = 2'b11;
    five_v = '0;  five_v[2:0] = 3'b101;
    four_v = '0;  four_v[2] = 1'b1;
    t64 = 64'h0000_0000_F0F0_000F; sw_a = t64[WIDTH-1:0];
    t64 = 64'h0000_0000_0000_FF24; sw_b = t64[WIDTH-1:0];

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    in_tag = '0;
    #22;
    n_chk++;
    if (out_valid !== 1'b0 || out_x !== '0 || out_tag !== '0 ||
        {out_z, out_n, out_c, out_v, out_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b x=%h tag=%0d flags=%b, required all 0",
               out_valid, out_x, out_tag, {out_z, out_n, out_c, out_v, out_err});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    idle(1);

    // Arithmetic flag corners and logic/shift sweep
    send(ones_v, one_v, 4'h0, 4'd1, 1'b0);
    send(maxp_v, one_v, 4'h0, 4'd2, 1'b0);
    send(three_v, five_v, 4'h1, 4'd3, 1'b0);
    for (int op = 0; op < 16; op++) send(sw_a, sw_b, 4'(op), TAG_W'(op), 1'b0);
    send(sw_a, four_v, 4'hA, 4'd5, 1'b0);
    drain();

    // Throughput: back-to-back ops with no backpressure
    for (int i = 0; i < 20; i++) send(rnd_w(), rnd_w(), 4'($urandom_range(0, 15)), TAG_W'(i), 1'b1);
    drain();
    n_chk++;
    if (tput_cnt != 20 || tput_last - tput_first != 19) begin
      n_fail++;
      $display("FAIL throughput: got %0d results over %0d cycles, required 20 over 19",
               tput_cnt, tput_last - tput_first);
    end

    // Backpressure: fill the pipe with the consumer stalled
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < PIPE_DEPTH; i++) send(rnd_w(), rnd_w(), 4'($urandom_range(0, 11)), TAG_W'(i), 1'b0);
    in_valid = 1'b1;
    in_a = rnd_w();
    in_b = rnd_w();
    in_op = 4'h7;
    in_tag = TAG_W'(9);
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_in_ready: got %0b, required 0", in_ready);
    end
    repeat (5) @(posedge clk);
    rdy_mode = 0;
    #1;
    send(in_a, in_b, 4'h7, TAG_W'(9), 1'b0);
    for (int i = 0; i < 4; i++) send(rnd_w(), rnd_w(), 4'($urandom_range(0, 15)), TAG_W'(10 + i), 1'b0);
    drain();

    // Reset with two operations in flight
    send(rnd_w(), rnd_w(), 4'h0, 4'd1, 1'b0);
    send(rnd_w(), rnd_w(), 4'h3, 4'd2, 1'b0);
    reset = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_x !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got v=%0b x=%h, required v=0 x=0", out_valid, out_x);
    end
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    end
    for (int i = 0; i < PIPE_DEPTH + 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_result: got out_valid=%0b, required 0", out_valid);
      end
    end
    idle(1);

    // Random ops with random input gaps and consumer stalls
    rdy_mode = 2;
    for (int i = 0; i < 1200; i++) begin
      send(rnd_w(), rnd_w(), 4'($urandom_range(0, 15)), TAG_W'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    rdy_mode = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
